sram_bus_arbiter: RTL and testbench

//  Shares one asynchronous SRAM chip between the instruction bus (read-only) and the data bus
//  (read/write) behind the CPU. Grants one requester per access, runs a multi-cycle SRAM

---
 rtl/sram_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one asynchronous SRAM between the instruction bus
// (read-only) and the data bus (read/write). One access at a time, granted
// from IDLE only, with programmable read/write wait states and a one-cycle ack.
// Every pad-facing output is a flop so the top-level tristate pads see clean edges.
module sram_bus_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int READ_WAIT     = 1,
    parameter int WRITE_WAIT    = 2,
    parameter int MAX_IBUS_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ibus_req,
    input  logic [ADDR_W-1:0]     ibus_addr,
    output logic [DATA_W-1:0]     ibus_rdata,
    output logic                  ibus_ack,
    input  logic                  dbus_req,
    input  logic                  dbus_we,
    input  logic [DATA_W/8-1:0]   dbus_be,
    input  logic [ADDR_W-1:0]     dbus_addr,
    input  logic [DATA_W-1:0]     dbus_wdata,
    output logic [DATA_W-1:0]     dbus_rdata,
    output logic                  dbus_ack,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  sram_drive,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n
);

    localparam int CNT_MAX = (READ_WAIT + 1 > WRITE_WAIT) ? READ_WAIT + 1 : WRITE_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STV_W   = $clog2(MAX_IBUS_WAIT + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WP_LAST = CNT_W'(WRITE_WAIT - 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(MAX_IBUS_WAIT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WS   = 3'd2;
    localparam logic [2:0] S_WP   = 3'd3;
    localparam logic [2:0] S_WH   = 3'd4;
    localparam logic [2:0] S_ACK  = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [STV_W-1:0] starve;
    logic             owner_ibus;
    logic             any_req;
    logic             grant_ibus;

    // dbus normally wins; ibus only loses MAX_IBUS_WAIT times in a row
    assign any_req    = ibus_req | dbus_req;
    assign grant_ibus = ibus_req & (~dbus_req | (starve == STV_MAX));

    // Count consecutive dbus wins that left ibus waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (state == S_IDLE && any_req) begin
            if (grant_ibus || !ibus_req)
                starve <= '0;
            else if (starve != STV_MAX)
                starve <= starve + 1'b1;
        end
    end

    // Access FSM: grant in IDLE, run the SRAM cycle, pulse the owner's ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner_ibus <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_drive <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
            ibus_ack   <= 1'b0;
            dbus_ack   <= 1'b0;
            ibus_rdata <= '0;
            dbus_rdata <= '0;
        end else begin
            ibus_ack <= 1'b0;
            dbus_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_ibus <= grant_ibus;
                        cnt        <= '0;
                        sram_addr  <= grant_ibus ? ibus_addr : dbus_addr;
                        sram_ce_n  <= 1'b0;
                        if (!grant_ibus && dbus_we) begin
                            sram_wdata <= dbus_wdata;
                            sram_be_n  <= ~dbus_be;
                            sram_drive <= 1'b1;
                            state      <= S_WS;
                        end else begin
                            sram_be_n <= '0;
                            sram_oe_n <= 1'b0;
                            state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (cnt == RD_LAST) begin
                        if (owner_ibus) begin
                            ibus_rdata <= sram_rdata;
                            ibus_ack   <= 1'b1;
                        end else begin
                            dbus_rdata <= sram_rdata;
                            dbus_ack   <= 1'b1;
                        end
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= '1;
                        state     <= S_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WS: begin
                    // address/data settle one cycle before we_n falls
                    sram_we_n <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WP;
                end
                S_WP: begin
                    if (cnt == WP_LAST) begin
                        sram_we_n <= 1'b1;
                        state     <= S_WH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WH: begin
                    // data held one cycle past we_n rise, then release the pads
                    sram_drive <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_be_n  <= '1;
                    dbus_ack   <= 1'b1;
                    state      <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized transaction rounds scored against a memory-level model.
module tb_sram_bus_arbiter;

    localparam int AW = 20, DW = 32, BW = 4, RW = 1, WW = 2, MAXW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance (default timing)
    logic          ibus_req, ibus_ack, dbus_req, dbus_we, dbus_ack;
    logic [AW-1:0] ibus_addr, dbus_addr, sram_addr;
    logic [DW-1:0] ibus_rdata, dbus_rdata, dbus_wdata, sram_wdata, sram_rdata;
    logic [BW-1:0] dbus_be, sram_be_n;
    logic          sram_drive, sram_ce_n, sram_oe_n, sram_we_n;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW), .WRITE_WAIT(WW),
                       .MAX_IBUS_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_rdata(ibus_rdata), .ibus_ack(ibus_ack),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    // fast instance (READ_WAIT=0, WRITE_WAIT=1)
    logic          f_ibus_req, f_ibus_ack, f_dbus_req, f_dbus_we, f_dbus_ack;
    logic [AW-1:0] f_ibus_addr, f_dbus_addr, f_sram_addr;
    logic [DW-1:0] f_ibus_rdata, f_dbus_rdata, f_dbus_wdata, f_sram_wdata, f_sram_rdata;
    logic [BW-1:0] f_dbus_be, f_sram_be_n;
    logic          f_sram_drive, f_sram_ce_n, f_sram_oe_n, f_sram_we_n;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(0), .WRITE_WAIT(1),
                       .MAX_IBUS_WAIT(MAXW)) fdut (
        .clk(clk), .rst_n(rst_n),
        .ibus_req(f_ibus_req), .ibus_addr(f_ibus_addr), .ibus_rdata(f_ibus_rdata), .ibus_ack(f_ibus_ack),
        .dbus_req(f_dbus_req), .dbus_we(f_dbus_we), .dbus_be(f_dbus_be), .dbus_addr(f_dbus_addr),
        .dbus_wdata(f_dbus_wdata), .dbus_rdata(f_dbus_rdata), .dbus_ack(f_dbus_ack),
        .sram_addr(f_sram_addr), .sram_wdata(f_sram_wdata), .sram_rdata(f_sram_rdata),
        .sram_drive(f_sram_drive), .sram_ce_n(f_sram_ce_n), .sram_oe_n(f_sram_oe_n),
        .sram_we_n(f_sram_we_n), .sram_be_n(f_sram_be_n)
    );

    assign f_sram_rdata = (!f_sram_ce_n && !f_sram_oe_n) ? {12'hF00, f_sram_addr} : 32'h0BAD0BAD;

    // pin-level SRAM model for the main instance, indexed by the low address byte
    logic [31:0] mem [0:255];
    logic        mem_init;

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (b == 8'h10) return 32'hDEADBEEF;
        if (b == 8'h20) return 32'h0;
        return {4{b}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0BAD0BAD;

    // pad contention, double ack, or write strobe outside chip select
    int hazard_cnt = 0;
    always @(negedge clk)
        if (rst_n && ((!sram_oe_n && sram_drive) || (ibus_ack && dbus_ack) ||
                      (!sram_we_n && sram_ce_n)))
            hazard_cnt <= hazard_cnt + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // behavioural model state
    logic [31:0] model_mem [0:255];
    logic [31:0] last_drd;
    logic [31:0] last_ird;
    int          s_model;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        int          exp_ack;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be_n;
        int          exp_drv;
        int          exp_wel;
    } vec_t;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        int          exp_ack;
        logic [31:0] exp_rdata;
    } txn_t;

    vec_t vt[8];

    // single isolated access from a table row; entered and left at posedge+1 of an IDLE cycle
    task automatic run_vec(input int k, input vec_t v);
        int ack_c, drv, wel, bad_addr, bad_be, other;
        logic [31:0] rd;
        string tag;
        ack_c = -1; drv = 0; wel = 0; bad_addr = 0; bad_be = 0; other = 0; rd = '0;
        tag = $sformatf("vec%0d", k);
        if (v.is_d) begin
            dbus_req = 1; dbus_we = v.we; dbus_be = v.be; dbus_addr = v.addr; dbus_wdata = v.wdata;
        end else begin
            ibus_req = 1; ibus_addr = v.addr;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!sram_ce_n) begin
                if (sram_addr !== v.addr) bad_addr++;
                if (sram_be_n !== v.exp_be_n) bad_be++;
            end
            if (sram_drive) drv++;
            if (!sram_we_n) wel++;
            if (v.is_d ? ibus_ack : dbus_ack) other++;
            if ((v.is_d ? dbus_ack : ibus_ack) && ack_c < 0) begin
                ack_c = c;
                rd = v.is_d ? dbus_rdata : ibus_rdata;
            end
            @(posedge clk); #1;
            if (ack_c >= 0) break;
        end
        ibus_req = 0; dbus_req = 0;
        chk({tag, " ack cycle"}, 64'(ack_c), 64'(v.exp_ack));
        chk({tag, " sram_addr"}, 64'(bad_addr), 0);
        chk({tag, " be_n"}, 64'(bad_be), 0);
        chk({tag, " drive cycles"}, 64'(drv), 64'(v.exp_drv));
        chk({tag, " we_n low cycles"}, 64'(wel), 64'(v.exp_wel));
        chk({tag, " other ack"}, 64'(other), 0);
        if (v.is_d && v.we) begin
            model_mem[v.addr[7:0]] = merge(model_mem[v.addr[7:0]], v.wdata, v.be);
            chk({tag, " dbus_rdata held"}, rd, last_drd);
        end else begin
            chk({tag, " rdata"}, rd, v.exp_rdata);
            if (v.is_d) last_drd = v.exp_rdata; else last_ird = v.exp_rdata;
        end
        if (!v.is_d) s_model = 0;
        else s_model = 0;
    endtask

    // random round: optional ibus read plus nd back-to-back dbus accesses
    task automatic run_round(input int r, input int nd, input bit use_i);
        txn_t dq[8];
        txn_t it;
        int t, di, lat, c;
        bit ipend, pick_i, done;
        for (int k = 0; k < nd; k++) begin
            dq[k].we    = 1'($urandom);
            dq[k].be    = 4'($urandom);
            dq[k].addr  = 20'($urandom) & 20'hFFF0F;
            dq[k].wdata = $urandom;
        end
        it.we = 0; it.be = 0; it.wdata = 0;
        it.addr = 20'($urandom) & 20'hFFF0F;
        // expected order and timing from the arbitration rule
        t = 0; di = 0; ipend = use_i;
        while (di < nd || ipend) begin
            pick_i = ipend && (di >= nd || s_model == MAXW);
            if (pick_i) begin
                s_model = 0;
                lat = RW + 2;
                it.exp_ack = t + lat;
                it.exp_rdata = model_mem[it.addr[7:0]];
                ipend = 0;
            end else begin
                s_model = ipend ? ((s_model < MAXW) ? s_model + 1 : MAXW) : 0;
                lat = dq[di].we ? WW + 3 : RW + 2;
                dq[di].exp_ack = t + lat;
                if (dq[di].we)
                    model_mem[dq[di].addr[7:0]] = merge(model_mem[dq[di].addr[7:0]], dq[di].wdata, dq[di].be);
                else
                    dq[di].exp_rdata = model_mem[dq[di].addr[7:0]];
                di++;
            end
            t = t + lat + 1;
        end
        // drive the masters
        di = 0; ipend = use_i; done = 0;
        for (c = 0; c < 400; c++) begin
            ibus_req = ipend; ibus_addr = it.addr;
            if (di < nd) begin
                dbus_req = 1; dbus_we = dq[di].we; dbus_be = dq[di].be;
                dbus_addr = dq[di].addr; dbus_wdata = dq[di].wdata;
            end else begin
                dbus_req = 0;
            end
            @(negedge clk);
            if (ibus_ack) begin
                chk($sformatf("rnd%0d ibus ack cycle", r), 64'(c), ipend ? 64'(it.exp_ack) : 64'(-1));
                chk($sformatf("rnd%0d ibus rdata", r), ibus_rdata, it.exp_rdata);
                ipend = 0;
            end
            if (dbus_ack) begin
                if (di >= nd) begin
                    chk($sformatf("rnd%0d stray dbus ack", r), 64'(c), 64'(-1));
                end else begin
                    chk($sformatf("rnd%0d dbus%0d ack cycle", r, di), 64'(c), 64'(dq[di].exp_ack));
                    if (!dq[di].we) last_drd = dq[di].exp_rdata;
                    chk($sformatf("rnd%0d dbus%0d rdata", r, di), dbus_rdata, last_drd);
                    di++;
                end
            end
            if (di >= nd && !ipend) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) chk($sformatf("rnd%0d timeout", r), 64'(c), 0);
        @(posedge clk); #1;
        ibus_req = 0; dbus_req = 0;
    endtask

    initial begin
        int ack_c, wel, n, hold_bad, nd;
        int fack[3];
        bit got_order[10];
        bit exp_order[10];
        logic [31:0] flast;
        rst_n = 1; mem_init = 1;
        ibus_req = 0; ibus_addr = 0; dbus_req = 0; dbus_we = 0; dbus_be = 0; dbus_addr = 0; dbus_wdata = 0;
        f_ibus_req = 0; f_ibus_addr = 0; f_dbus_req = 0; f_dbus_we = 0; f_dbus_be = 0;
        f_dbus_addr = 0; f_dbus_wdata = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = pat(i);
        last_drd = 0; last_ird = 0; s_model = 0;

        vt[0] = '{0, 0, 4'h0, 20'h00010, 32'h0,        3, 32'hDEADBEEF, 4'h0, 0, 0};
        vt[1] = '{1, 1, 4'h5, 20'h00020, 32'h12345678, 5, 32'h0,        4'hA, 4, 2};
        vt[2] = '{1, 0, 4'h0, 20'h00020, 32'h0,        3, 32'h00340078, 4'h0, 0, 0};
        vt[3] = '{1, 1, 4'h0, 20'h00030, 32'hFFFFFFFF, 5, 32'h0,        4'hF, 4, 2};
        vt[4] = '{1, 0, 4'h0, 20'h00030, 32'h0,        3, 32'h30303030, 4'h0, 0, 0};
        vt[5] = '{0, 0, 4'h0, 20'hABC55, 32'h0,        3, 32'h55555555, 4'h0, 0, 0};
        vt[6] = '{1, 1, 4'hF, 20'hFFFFF, 32'hCAFEF00D, 5, 32'h0,        4'h0, 4, 2};
        vt[7] = '{0, 0, 4'h0, 20'hFFFFF, 32'h0,        3, 32'hCAFEF00D, 4'h0, 0, 0};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ce/oe/we", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        chk("reset be_n", sram_be_n, 4'hF);
        chk("reset drive", sram_drive, 0);
        chk("reset addr/wdata", {sram_addr, sram_wdata}, 0);
        chk("reset acks", {ibus_ack, dbus_ack}, 0);
        chk("reset rdata", {ibus_rdata, dbus_rdata}, 0);
        chk("fast reset pins", {f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_drive, f_ibus_ack, f_dbus_ack}, 6'b111000);
        mem_init = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // table vectors
        for (int k = 0; k < 8; k++) run_vec(k, vt[k]);

        // both read requests held: dbus wins four times, then ibus is forced through
        n = 0;
        ibus_req = 1; ibus_addr = 20'h00010;
        dbus_req = 1; dbus_we = 0; dbus_addr = 20'h00030;
        for (int c = 0; c < 120 && n < 10; c++) begin
            @(negedge clk);
            if (ibus_ack && dbus_ack) chk("stream ack overlap", 1, 0);
            if (dbus_ack) begin
                chk("stream dbus rdata", dbus_rdata, 32'h30303030);
                got_order[n] = 1; n++;
            end else if (ibus_ack) begin
                chk("stream ibus rdata", ibus_rdata, 32'hDEADBEEF);
                got_order[n] = 0; n++;
            end
            @(posedge clk); #1;
        end
        ibus_req = 0; dbus_req = 0;
        last_drd = 32'h30303030; s_model = 0;
        chk("stream ack count", 64'(n), 10);
        for (int k = 0; k < 10; k++) chk($sformatf("grant order %0d", k), got_order[k], exp_order[k]);

        // reset asserted mid write pulse
        dbus_req = 1; dbus_we = 1; dbus_be = 4'hF; dbus_addr = 20'h00040; dbus_wdata = 32'h99999999;
        wel = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!sram_we_n) begin wel = 1; break; end
        end
        chk("reached write pulse", 64'(wel), 1);
        #1 rst_n = 0;
        #1;
        chk("rst in WP ce/we/oe", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        chk("rst in WP drive", sram_drive, 0);
        chk("rst in WP acks", {ibus_ack, dbus_ack}, 0);
        chk("rst in WP rdata", {ibus_rdata, dbus_rdata}, 0);
        dbus_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        last_drd = 0; last_ird = 0; s_model = 0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ibus_ack || dbus_ack || !sram_ce_n) n++;
        end
        chk("idle after reset release", 64'(n), 0);
        @(posedge clk); #1;

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            nd = $urandom_range(0, 6);
            if (nd == 0) run_round(r, 0, 1'b1);
            else run_round(r, nd, 1'($urandom));
        end

        // fast build: back-to-back ibus reads
        n = 0; hold_bad = 0; flast = 0;
        fack[0] = -1; fack[1] = -1; fack[2] = -1;
        f_ibus_req = 1; f_ibus_addr = 20'd1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (f_ibus_ack) begin
                fack[n] = c;
                chk($sformatf("fast rdata %0d", n), f_ibus_rdata, {12'hF00, 20'(n + 1)});
                flast = {12'hF00, 20'(n + 1)};
                n++;
            end else if (n > 0 && f_ibus_rdata !== flast) begin
                hold_bad++;
            end
            if (n == 3) break;
            @(posedge clk); #1;
            f_ibus_addr = 20'(n + 1);
        end
        @(posedge clk); #1;
        f_ibus_req = 0;
        chk("fast read ack 0", 64'(fack[0]), 2);
        chk("fast read ack 1", 64'(fack[1]), 5);
        chk("fast read ack 2", 64'(fack[2]), 8);
        chk("fast rdata hold", 64'(hold_bad), 0);

        // fast build: single write
        ack_c = -1; wel = 0; n = 0;
        f_dbus_req = 1; f_dbus_we = 1; f_dbus_be = 4'hF; f_dbus_addr = 20'h5; f_dbus_wdata = 32'hAAAA5555;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!f_sram_we_n) begin
                wel++;
                if (f_sram_be_n !== 4'h0 || f_sram_wdata !== 32'hAAAA5555) n++;
            end
            if (f_dbus_ack) begin ack_c = c; break; end
            @(posedge clk); #1;
        end
        chk("fast write ack", 64'(ack_c), 4);
        chk("fast we_n low cycles", 64'(wel), 1);
        chk("fast write pins", 64'(n), 0);
        chk("fast write dbus_rdata", f_dbus_rdata, 0);
        @(posedge clk); #1;
        f_dbus_req = 0;
        repeat (2) @(posedge clk);

        chk("pin hazards", 64'(hazard_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
